nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
// PURPOSE
//   Sequencer that performs wide add/subtract by time-multiplexing one four_bit_adder slice.
//   Operands are processed one nibble per cycle, LSB nibble first, carry chained through a register.
//   It sits between a valid/ready requester and a valid/ready consumer of results.
//   Trades area (one 4-bit slice) for latency (NIBBLES cycles per operation).
// PARAMETERS
//   NIBBLES  4  operand width in nibbles; W = 4*NIBBLES (must be >= 1)
// PORTS
//   clk        in   1  single clock, all state updates on rising edge
//   rst        in   1  asynchronous, active-high reset
//   in_valid   in   1  request present: a, b, cin, sub valid
//   in_ready   out  1  controller can accept a request
//   a          in   W  operand A, bit 0 = LSB
//   b          in   W  operand B, bit 0 = LSB
//   cin        in   1  carry-in for add (ignored when sub=1)
//   sub        in   1  1 = compute a - b (b inverted, carry-in forced 1)
//   out_valid  out  1  result registers hold a completed result
//   out_ready  in   1  consumer accepts result
//   sum        out  W  result, bit 0 = LSB
//   cout       out  1  carry out of nibble NIBBLES-1 (subtract: 1 = no borrow)
//   overflow   out  1  signed overflow of the final nibble (carry into MSB ^ carry out)
//   busy       out  1  state != IDLE
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, idx=0, carry=0, sum=0, cout=0, overflow=0,
//     out_valid=0; in_ready=1 and busy=0 while rst is high and after release.
//   FSM states: IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
//   IDLE: on edge with in_valid&in_ready -> latch A=a, B = sub ? ~b : b,
//     carry = sub ? 1 : cin, idx=0, clear sum/cout/overflow, go RUN. No request: hold.
//   RUN: slice inputs x=A[4*idx+:4], y=B[4*idx+:4], carry_in=carry. Each edge:
//     sum[4*idx+:4] <= slice sum, carry <= slice carry_out.
//     If idx==NIBBLES-1: cout <= slice carry_out, overflow <= slice overflow, go DONE.
//     Else idx <= idx+1. idx width = max(1,clog2(NIBBLES)), never exceeds NIBBLES-1.
//   DONE: sum/cout/overflow held stable. On edge with out_ready -> IDLE.
//     out_ready low: hold indefinitely (backpressure), no timeout.
//   Latency: out_valid rises exactly NIBBLES edges after the accept edge.
//   Max throughput: one op per NIBBLES+2 cycles (accept, NIBBLES run, >=1 DONE).
//   in_valid while not IDLE: ignored, not queued; requester must hold it until in_ready.
//   a/b/cin/sub changing during RUN: no effect (latched at accept).
//   out_ready while not DONE: ignored.
//   NIBBLES=1: RUN lasts one cycle; result equals a single four_bit_adder evaluation.
//   Arithmetic is modulo 2^W; no saturation.
//   Reset mid-RUN or mid-DONE: operation discarded, no result emitted, outputs return to reset values.
// TESTING (NIBBLES=4)
//   Add a=0x1234 b=0x4321 cin=0 -> sum=0x5555 cout=0 ovf=0; out_valid 4 edges after accept.
//   Carry ripple across nibbles: a=0xFFFF b=0x0001 cin=0 -> sum=0x0000 cout=1 ovf=0.
//   Signed overflow: a=0x7FFF b=0x0001 -> sum=0x8000 cout=0 ovf=1;
//     also a=0x0000 b=0x0000 cin=1 -> sum=0x0001.
//   Subtract: sub=1 a=0x0005 b=0x0007 -> sum=0xFFFE cout=0 ovf=0;
//     a=0x8000 b=0x0001 -> sum=0x7FFF ovf=1.
//   Backpressure: hold out_ready=0 for 3 cycles in DONE, pulse in_valid with new operands ->
//     sum stable, in_ready=0, new request not taken; out_ready=1 -> IDLE, then request accepted.
//   Reset mid-op: assert rst 2 cycles after accept -> out_valid=0, sum=0, busy=0 immediately;
//     no result appears after release; next request completes normally.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract sequencer: one 4-bit adder slice is reused once per nibble, LSB nibble first,
// with the carry kept in a register between cycles. Valid/ready handshakes on both sides.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   overflow,
  output logic                   busy
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state, state_nxt;
  logic [NIBBLES-1:0][3:0]   a_q, b_q, sum_q;
  logic [IW-1:0]             idx;
  logic                      carry, cout_q, ovf_q;

  logic [3:0]                x, y, slice_sum;
  logic [3:0]                low;
  logic [1:0]                top;
  logic                      slice_cout, slice_ovf;
  logic                      accept;

  assign accept    = in_valid & in_ready;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

  // Slice split at bit 3 so the carry into the MSB is visible for signed overflow.
  always_comb begin
    x          = a_q[idx];
    y          = b_q[idx];
    low        = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, carry};
    top        = {1'b0, x[3]} + {1'b0, y[3]} + {1'b0, low[3]};
    slice_sum  = {top[0], low[2:0]};
    slice_cout = top[1];
    slice_ovf  = low[3] ^ top[1];
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= a;
            b_q    <= sub ? ~b : b;
            carry  <= sub | cin;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
          end
        end
        RUN: begin
          sum_q[idx] <= slice_sum;
          carry      <= slice_cout;
          if (idx == LAST_IDX) begin
            cout_q <= slice_cout;
            ovf_q  <= slice_ovf;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (NIBBLES=4): vector table plus
// backpressure and mid-operation reset sequences.
module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow, busy;
  logic [W-1:0] a, b, sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .busy(busy)
  );

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for out_valid after an accept edge; returns number of edges taken (bounded).
  task automatic wait_result(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int edges;
    @(negedge clk);
    check({v.name, " in_ready"}, in_ready, 1);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs during RUN; the latched operands must be used.
    a = ~v.a; b = ~v.b; cin = ~v.cin; sub = ~v.sub;
    check({v.name, " busy"}, busy, 1);
    wait_result(edges);
    check({v.name, " latency"}, edges, NIBBLES);
    check({v.name, " sum"}, sum, v.exp_sum);
    check({v.name, " cout"}, cout, v.exp_cout);
    check({v.name, " ovf"}, overflow, v.exp_ovf);
    check({v.name, " in_ready_done"}, in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({v.name, " out_valid_clr"}, out_valid, 0);
  endtask

  vec_t vecs[9];

  initial begin
    int edges;
    vecs[0] = '{"add_basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{"ripple",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"ovf_pos",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{"cin_only",   16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{"sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{"sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{"sub_cin_ig", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[7] = '{"ovf_neg",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{"add_cin",    16'h0F0F, 16'h00F0, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("rst in_ready", in_ready, 1);
    check("rst busy", busy, 0);
    check("rst out_valid", out_valid, 0);
    check("rst sum", sum, 0);
    check("rst cout", cout, 0);
    check("rst ovf", overflow, 0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result held in DONE, new request ignored until IDLE.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(edges);
    check("bp latency", edges, NIBBLES);
    a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp sum", sum, 16'h3333);
      check("bp out_valid", out_valid, 1);
      check("bp in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp idle out_valid", out_valid, 0);
    check("bp idle in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp accept busy", busy, 1);
    wait_result(edges);
    check("bp2 latency", edges, NIBBLES);
    check("bp2 sum", sum, 16'h0002);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset two cycles after accept: operation discarded.
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid sum partial", sum, 16'h0022);
    rst = 1'b1; #1;
    check("mid rst out_valid", out_valid, 0);
    check("mid rst sum", sum, 0);
    check("mid rst busy", busy, 0);
    check("mid rst in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    edges = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) edges++;
    end
    check("mid no result", edges, 0);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
